// File: rtl/line_draw_sequencer.sv
// Pops line descriptors from the line queue, runs a start/done handshake with the
// rasterizer under a watchdog, and performs a framebuffer swap once a flushed frame drains.
module line_draw_sequencer #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_empty,
  input  logic [12:0]      q_start_x,
  input  logic [12:0]      q_end_x,
  input  logic [12:0]      q_start_y,
  input  logic [12:0]      q_end_y,
  input  logic [3:0]       q_intensity,
  output logic             q_read,
  output logic [12:0]      line_start_x,
  output logic [12:0]      line_end_x,
  output logic [12:0]      line_start_y,
  output logic [12:0]      line_end_y,
  output logic [3:0]       line_intensity,
  output logic             rast_start,
  output logic             rast_abort,
  input  logic             rast_done,
  input  logic             frame_end,
  output logic             swap_req,
  input  logic             swap_ack,
  output logic             busy,
  output logic [CNT_W-1:0] lines_drawn,
  output logic [CNT_W-1:0] last_frame_lines,
  output logic [CNT_W-1:0] skipped,
  output logic             timeout_err,
  output logic             flush_overrun
);
  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, POP, START, WAIT, SWAP} state_t;

  state_t           state_q, state_d;
  logic [12:0]      sx_q, sx_d, ex_q, ex_d, sy_q, sy_d, ey_q, ey_d;
  logic [3:0]       int_q, int_d;
  logic             q_read_q, q_read_d;
  logic             rast_start_q, rast_start_d;
  logic             rast_abort_q, rast_abort_d;
  logic             swap_req_q, swap_req_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] lines_q, lines_d, last_q, last_d, skipped_q, skipped_d;
  logic             timeout_err_q, timeout_err_d;
  logic             flush_overrun_q, flush_overrun_d;
  logic             flush_pending_q, flush_pending_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             line_done, line_skip, swap_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      sx_q            <= '0;
      ex_q            <= '0;
      sy_q            <= '0;
      ey_q            <= '0;
      int_q           <= '0;
      q_read_q        <= 1'b0;
      rast_start_q    <= 1'b0;
      rast_abort_q    <= 1'b0;
      swap_req_q      <= 1'b0;
      busy_q          <= 1'b0;
      lines_q         <= '0;
      last_q          <= '0;
      skipped_q       <= '0;
      timeout_err_q   <= 1'b0;
      flush_overrun_q <= 1'b0;
      flush_pending_q <= 1'b0;
      wd_q            <= '0;
    end else begin
      state_q         <= state_d;
      sx_q            <= sx_d;
      ex_q            <= ex_d;
      sy_q            <= sy_d;
      ey_q            <= ey_d;
      int_q           <= int_d;
      q_read_q        <= q_read_d;
      rast_start_q    <= rast_start_d;
      rast_abort_q    <= rast_abort_d;
      swap_req_q      <= swap_req_d;
      busy_q          <= busy_d;
      lines_q         <= lines_d;
      last_q          <= last_d;
      skipped_q       <= skipped_d;
      timeout_err_q   <= timeout_err_d;
      flush_overrun_q <= flush_overrun_d;
      flush_pending_q <= flush_pending_d;
      wd_q            <= wd_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    sx_d            = sx_q;
    ex_d            = ex_q;
    sy_d            = sy_q;
    ey_d            = ey_q;
    int_d           = int_q;
    lines_d         = lines_q;
    last_d          = last_q;
    skipped_d       = skipped_q;
    timeout_err_d   = timeout_err_q;
    flush_overrun_d = flush_overrun_q;
    flush_pending_d = flush_pending_q;
    wd_d            = wd_q;
    rast_abort_d    = 1'b0;
    line_done       = 1'b0;
    line_skip       = 1'b0;
    swap_done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          sx_d    = q_start_x;
          ex_d    = q_end_x;
          sy_d    = q_start_y;
          ey_d    = q_end_y;
          int_d   = q_intensity;
          state_d = POP;
        end else if (flush_pending_q) begin
          state_d = SWAP;
        end
      end
      POP: begin
        if (int_q == 4'd0) begin
          line_skip = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // A done pulse in the expiry cycle still counts as a completed line.
        if (rast_done) begin
          line_done = 1'b1;
          state_d   = IDLE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          rast_abort_d  = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      SWAP: begin
        if (swap_ack) begin
          swap_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (line_done && lines_q != '1) lines_d = lines_q + 1'b1;
    if (line_skip && skipped_q != '1) skipped_d = skipped_q + 1'b1;
    if (swap_done) begin
      last_d    = lines_d;
      lines_d   = '0;
      skipped_d = '0;
    end

    // A request landing on the swap-completion edge seeds the next frame's flush.
    if (swap_done) begin
      flush_pending_d = frame_end;
    end else if (frame_end) begin
      if (flush_pending_q) flush_overrun_d = 1'b1;
      else                 flush_pending_d = 1'b1;
    end

    // Watchdog is zero during the start cycle, so expiry lands TIMEOUT cycles after rast_start.
    if (state_d == START) wd_d = '0;
    else if (state_q == START || state_q == WAIT) wd_d = wd_q + 1'b1;

    q_read_d     = (state_d == POP);
    rast_start_d = (state_d == START);
    swap_req_d   = (state_d == SWAP);
    busy_d       = (state_d != IDLE);
  end

  assign q_read           = q_read_q;
  assign rast_start       = rast_start_q;
  assign rast_abort       = rast_abort_q;
  assign swap_req         = swap_req_q;
  assign busy             = busy_q;
  assign line_start_x     = sx_q;
  assign line_end_x       = ex_q;
  assign line_start_y     = sy_q;
  assign line_end_y       = ey_q;
  assign line_intensity   = int_q;
  assign lines_drawn      = lines_q;
  assign last_frame_lines = last_q;
  assign skipped          = skipped_q;
  assign timeout_err      = timeout_err_q;
  assign flush_overrun    = flush_overrun_q;
endmodule

// File: tb/tb_line_draw_sequencer.sv
// Directed bench for line_draw_sequencer: small queue model, auto-responding rasterizer
// and swap acknowledge, cycle-exact checks against hand-derived timelines.
module tb_line_draw_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        q_empty = 1'b1;
  logic [12:0] q_start_x = '0, q_end_x = '0, q_start_y = '0, q_end_y = '0;
  logic [3:0]  q_intensity = '0;
  logic        q_read;
  logic [12:0] line_start_x, line_end_x, line_start_y, line_end_y;
  logic [3:0]  line_intensity;
  logic        rast_start, rast_abort;
  logic        rast_done = 1'b0;
  logic        frame_end = 1'b0;
  logic        swap_req;
  logic        swap_ack = 1'b0;
  logic        busy;
  logic [2:0]  lines_drawn, last_frame_lines, skipped;
  logic        timeout_err, flush_overrun;

  line_draw_sequencer #(.TIMEOUT(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty),
    .q_start_x(q_start_x), .q_end_x(q_end_x), .q_start_y(q_start_y), .q_end_y(q_end_y),
    .q_intensity(q_intensity), .q_read(q_read),
    .line_start_x(line_start_x), .line_end_x(line_end_x),
    .line_start_y(line_start_y), .line_end_y(line_end_y),
    .line_intensity(line_intensity), .rast_start(rast_start), .rast_abort(rast_abort),
    .rast_done(rast_done), .frame_end(frame_end), .swap_req(swap_req), .swap_ack(swap_ack),
    .busy(busy), .lines_drawn(lines_drawn), .last_frame_lines(last_frame_lines),
    .skipped(skipped), .timeout_err(timeout_err), .flush_overrun(flush_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [12:0] qsx[16], qex[16], qsy[16], qey[16];
  logic [3:0]  qint[16];
  int qcount = 0, qhead = 0;

  int done_delay = 0, done_cnt = 0, ack_delay = 0, ack_cnt = 0;
  int n_read, n_start, n_abort, n_rise, ab_cyc, fall_cyc, sw_lines, sw_skip;
  int rd_cyc[8], st_cyc[8], rise_cyc[8];
  logic prev_swap = 1'b0;
  int c0, c1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_head();
    if (qhead < qcount) begin
      q_empty = 1'b0; q_start_x = qsx[qhead]; q_end_x = qex[qhead];
      q_start_y = qsy[qhead]; q_end_y = qey[qhead]; q_intensity = qint[qhead];
    end else begin
      q_empty = 1'b1; q_start_x = 13'h1555; q_end_x = 13'h0aaa;
      q_start_y = 13'h1fff; q_end_y = 13'h0123; q_intensity = 4'hf;
    end
  endtask

  task automatic push(input logic [12:0] sx, input logic [12:0] ex, input logic [12:0] sy,
                      input logic [12:0] ey, input logic [3:0] it);
    qsx[qcount] = sx; qex[qcount] = ex; qsy[qcount] = sy; qey[qcount] = ey; qint[qcount] = it;
    qcount++;
    drive_head();
  endtask

  task automatic clear_stats();
    n_read = 0; n_start = 0; n_abort = 0; n_rise = 0;
    ab_cyc = -1; fall_cyc = -1; sw_lines = -1; sw_skip = -1;
    for (int i = 0; i < 8; i++) begin rd_cyc[i] = -1; st_cyc[i] = -1; rise_cyc[i] = -1; end
  endtask

  // One clock: sample outputs 1 time unit after the edge, then drive the next inputs.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    frame_end = 1'b0; rast_done = 1'b0; swap_ack = 1'b0;
    if (done_cnt > 0) begin done_cnt--; if (done_cnt == 0) rast_done = 1'b1; end
    if (ack_cnt > 0) begin ack_cnt--; if (ack_cnt == 0) swap_ack = 1'b1; end
    if (rast_start) begin
      if (n_start < 8) st_cyc[n_start] = cyc;
      n_start++;
      if (done_delay > 0) done_cnt = done_delay;
    end
    if (q_read) begin
      if (n_read < 8) rd_cyc[n_read] = cyc;
      n_read++;
      if (qhead < qcount) qhead++;
    end
    if (rast_abort) begin ab_cyc = cyc; n_abort++; end
    if (swap_req && !prev_swap) begin
      if (n_rise < 8) rise_cyc[n_rise] = cyc;
      n_rise++;
      sw_lines = int'(lines_drawn);
      sw_skip = int'(skipped);
      if (ack_delay > 0) ack_cnt = ack_delay;
    end
    if (!swap_req && prev_swap) fall_cyc = cyc;
    prev_swap = swap_req;
    drive_head();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; qcount = 0; qhead = 0;
    done_delay = 0; done_cnt = 0; ack_delay = 0; ack_cnt = 0;
    drive_head();
    step(); step();
    rst = 1'b0;
    clear_stats();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    clear_stats();
    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_q_read", q_read, 0);
    check("rst_swap_req", swap_req, 0);
    check("rst_lines", lines_drawn, 0);
    check("rst_last", last_frame_lines, 0);
    check("rst_skipped", skipped, 0);
    check("rst_flags", {timeout_err, flush_overrun}, 0);
    check("rst_line_x", line_start_x, 0);

    // Stray rast_done in IDLE is ignored
    rast_done = 1'b1;
    step();
    check("idle_done_ignored", lines_drawn, 0);

    // Single line, done 5 cycles after start
    clear_stats();
    c0 = cyc; done_delay = 5;
    push(13'd10, 13'd300, 13'd20, 13'd400, 4'd7);
    run(10);
    check("t1_read_lat", rd_cyc[0], c0 + 1);
    check("t1_start_lat", st_cyc[0], c0 + 2);
    check("t1_n_read", n_read, 1);
    check("t1_n_start", n_start, 1);
    check("t1_sx", line_start_x, 10);
    check("t1_ex", line_end_x, 300);
    check("t1_sy", line_start_y, 20);
    check("t1_ey", line_end_y, 400);
    check("t1_int", line_intensity, 7);
    check("t1_lines", lines_drawn, 1);
    check("t1_busy", busy, 0);

    // Intensities 5,0,9 with done 3 cycles after each start
    do_reset();
    c0 = cyc; done_delay = 3;
    push(13'd1, 13'd2, 13'd3, 13'd4, 4'd5);
    push(13'd5, 13'd6, 13'd7, 13'd8, 4'd0);
    push(13'd100, 13'd200, 13'd300, 13'd400, 4'd9);
    run(16);
    check("t2_n_read", n_read, 3);
    check("t2_n_start", n_start, 2);
    check("t2_lines", lines_drawn, 2);
    check("t2_skipped", skipped, 1);
    check("t2_pop_after_done", rd_cyc[1], c0 + 7);
    check("t2_pop_after_skip", rd_cyc[2], c0 + 9);
    check("t2_int", line_intensity, 9);
    check("t2_ey", line_end_y, 400);

    // End of frame with lines queued, swap_ack 4 cycles after swap_req rises
    do_reset();
    c0 = cyc; done_delay = 3; ack_delay = 4;
    push(13'd11, 13'd12, 13'd13, 13'd14, 4'd3);
    push(13'd21, 13'd22, 13'd23, 13'd24, 4'd0);
    push(13'd31, 13'd32, 13'd33, 13'd34, 4'd4);
    frame_end = 1'b1;
    run(24);
    check("t3_n_start", n_start, 2);
    check("t3_swap_rise", rise_cyc[0], c0 + 15);
    check("t3_lines_at_swap", sw_lines, 2);
    check("t3_skip_at_swap", sw_skip, 1);
    check("t3_swap_fall", fall_cyc, c0 + 20);
    check("t3_last", last_frame_lines, 2);
    check("t3_lines_clr", lines_drawn, 0);
    check("t3_skip_clr", skipped, 0);
    check("t3_one_swap", n_rise, 1);

    // Watchdog expiry, then next line, then done coinciding with expiry
    do_reset();
    c0 = cyc; done_delay = 0;
    push(13'd40, 13'd41, 13'd42, 13'd43, 4'd6);
    push(13'd50, 13'd51, 13'd52, 13'd53, 4'd2);
    run(10);
    check("t4_abort_now", rast_abort, 1);
    check("t4_abort_lat", ab_cyc, st_cyc[0] + 8);
    check("t4_timeout_err", timeout_err, 1);
    check("t4_lines_unch", lines_drawn, 0);
    done_delay = 3;
    run(8);
    check("t4_next_start", st_cyc[1], c0 + 12);
    check("t4_next_lines", lines_drawn, 1);
    check("t4_next_int", line_intensity, 2);
    check("t4_n_abort", n_abort, 1);
    done_delay = 7;
    push(13'd60, 13'd61, 13'd62, 13'd63, 4'd1);
    run(12);
    check("t4_coincide_abort", n_abort, 1);
    check("t4_coincide_lines", lines_drawn, 2);

    // frame_end on the swap-completion edge starts a second swap
    do_reset();
    c0 = cyc; ack_delay = 4;
    for (int i = 0; i < 20; i++) begin
      if (cyc == c0 || cyc == c0 + 6) frame_end = 1'b1;
      step();
    end
    check("t5_two_swaps", n_rise, 2);
    check("t5_second_rise", rise_cyc[1], c0 + 8);
    check("t5_no_overrun", flush_overrun, 0);
    // Second frame_end during SWAP before swap_ack
    clear_stats();
    c1 = cyc;
    for (int i = 0; i < 12; i++) begin
      if (cyc == c1 || cyc == c1 + 3) frame_end = 1'b1;
      step();
    end
    check("t5_overrun", flush_overrun, 1);
    check("t5_one_swap", n_rise, 1);
    check("t5_swap_low", swap_req, 0);

    // Reset in WAIT
    do_reset();
    c0 = cyc; done_delay = 0;
    push(13'd70, 13'd71, 13'd72, 13'd73, 4'd0);
    push(13'd80, 13'd81, 13'd82, 13'd83, 4'd5);
    run(6);
    check("t6_pre_skipped", skipped, 1);
    check("t6_pre_busy", busy, 1);
    rst = 1'b1;
    step();
    check("t6_wait_busy", busy, 0);
    check("t6_wait_skipped", skipped, 0);
    check("t6_wait_abort", rast_abort, 0);
    check("t6_wait_int", line_intensity, 0);
    rst = 1'b0; qcount = 0; qhead = 0; drive_head();
    clear_stats();
    run(10);
    check("t6_no_abort", n_abort, 0);
    check("t6_no_tmo", timeout_err, 0);
    // Reset in SWAP
    ack_delay = 0;
    frame_end = 1'b1;
    step(); step();
    check("t6_swap_up", swap_req, 1);
    rst = 1'b1;
    step();
    check("t6_swap_down", swap_req, 0);
    check("t6_swap_busy", busy, 0);
    rst = 1'b0;
    clear_stats();
    run(5);
    check("t6_no_reswap", n_rise, 0);

    // Skip counter saturates at all-ones
    do_reset();
    for (int i = 0; i < 9; i++) push(13'(i), 13'd0, 13'd0, 13'd0, 4'd0);
    run(20);
    check("t7_n_read", n_read, 9);
    check("t7_skip_sat", skipped, 7);
    check("t7_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
